// File: rtl/padlock_keypad_if.sv
`default_nettype none
// ============================================================================
// Module   : padlock_keypad_if
// Purpose  : Signal bundle between the keypad front end and its environment:
//            raw key inputs, padlock lock feedback, and the code/strobe/status
//            outputs that feed the padlock comparator.
// Revision : 1.0 - initial release
// ============================================================================
interface padlock_keypad_if;
  logic [9:0] key_raw;
  logic       enter_raw;
  logic       lock_in;
  logic [9:0] but;
  logic       open;
  logic       lockout;
  logic [1:0] fail_count;

  // Environment side: drives raw keys and lock feedback, observes outputs
  modport master (
    output key_raw, enter_raw, lock_in,
    input  but, open, lockout, fail_count
  );

  // Keypad side
  modport slave (
    input  key_raw, enter_raw, lock_in,
    output but, open, lockout, fail_count
  );
endinterface
`default_nettype wire

// File: rtl/padlock_keypad.sv
`default_nettype none
// ============================================================================
// Module   : padlock_keypad
// Purpose  : Keypad front end for the padlock comparator. Synchronizes and
//            debounces 10 digit keys plus enter, toggles a latched code
//            vector, issues a one-cycle open strobe, counts failed submits
//            from the padlock's lock output and enforces a timed lockout.
//            A half-entered code is cleared after an inactivity timeout.
// Revision : 1.0 - initial release
// ============================================================================
module padlock_keypad #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int MAX_FAILS       = 3,
  parameter int LOCKOUT_CYCLES  = 5000
) (
  input  logic             clk,
  input  logic             reset,
  padlock_keypad_if.slave  bus
);

  localparam int NUM_IN = 11;
  localparam int DW     = $clog2(DEBOUNCE_CYCLES);
  localparam int TW     = $clog2(TIMEOUT_CYCLES);
  localparam int LW     = $clog2(LOCKOUT_CYCLES + 1);
  localparam int FW     = $clog2(MAX_FAILS + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_SUBMIT  = 3'd2,
    S_CHECK   = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Input conditioning: bit 10 is enter, bits 9..0 are digit keys
  // --------------------------------------------------------------------------
  logic [NUM_IN-1:0] raw_all;
  logic [NUM_IN-1:0] sync1;
  logic [NUM_IN-1:0] sync2;
  logic [NUM_IN-1:0] deb;
  logic [NUM_IN-1:0] deb_d;
  logic [NUM_IN-1:0] press;

  assign raw_all = {bus.enter_raw, bus.key_raw};

  // Two-flop synchronizer for every raw input
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_all;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < NUM_IN; i++) begin : g_deb
    logic          level;
    logic [DW-1:0] cnt;

    // Accept a new level only after DEBOUNCE_CYCLES disagreeing samples in a row
    always_ff @(posedge clk) begin
      if (reset) begin
        level <= 1'b0;
        cnt   <= '0;
      end else if (sync2[i] != level) begin
        if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync2[i];
          cnt   <= '0;
        end else begin
          cnt <= cnt + DW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end

    assign deb[i] = level;
  end

  // Delayed debounced levels for rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_d <= '0;
    end else begin
      deb_d <= deb;
    end
  end

  assign press = deb & ~deb_d;

  logic [9:0] key_press;
  logic       enter_press;

  assign key_press   = press[9:0];
  assign enter_press = press[10];

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  state_t        state, state_n;
  logic [9:0]    but_q, but_n;
  logic [TW-1:0] timer, timer_n;
  logic [LW-1:0] lock_cnt, lock_cnt_n;
  logic [FW-1:0] fails, fails_n;
  logic          open_q, lockout_q;
  logic [1:0]    fail_count_q;
  logic [1:0]    fail_sat;

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      but_q        <= '0;
      timer        <= '0;
      lock_cnt     <= '0;
      fails        <= '0;
      open_q       <= 1'b0;
      lockout_q    <= 1'b0;
      fail_count_q <= '0;
    end else begin
      state        <= state_n;
      but_q        <= but_n;
      timer        <= timer_n;
      lock_cnt     <= lock_cnt_n;
      fails        <= fails_n;
      open_q       <= (state_n == S_SUBMIT);
      lockout_q    <= (state_n == S_LOCKOUT);
      fail_count_q <= fail_sat;
    end
  end

  // Next-state and next-value logic; presses are only honoured in IDLE/ENTRY
  always_comb begin
    state_n    = state;
    but_n      = but_q;
    timer_n    = timer;
    lock_cnt_n = lock_cnt;
    fails_n    = fails;

    case (state)
      S_IDLE: begin
        if (enter_press) begin
          but_n   = '0;
          state_n = S_SUBMIT;
        end else if (|key_press) begin
          but_n   = but_q ^ key_press;
          timer_n = '0;
          state_n = S_ENTRY;
        end
      end

      S_ENTRY: begin
        if (enter_press) begin
          // digits arriving together with enter are dropped
          state_n = S_SUBMIT;
        end else if (|key_press) begin
          but_n   = but_q ^ key_press;
          timer_n = '0;
        end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          but_n   = '0;
          timer_n = '0;
          state_n = S_IDLE;
        end else begin
          timer_n = timer + TW'(1);
        end
      end

      S_SUBMIT: begin
        state_n = S_CHECK;
      end

      S_CHECK: begin
        // lock_in now carries the padlock's verdict on the submitted code
        if (bus.lock_in) begin
          if (fails != FW'(MAX_FAILS)) begin
            fails_n = fails + FW'(1);
          end
        end else begin
          fails_n = '0;
        end
        but_n = '0;
        if (fails_n == FW'(MAX_FAILS)) begin
          lock_cnt_n = '0;
          state_n    = S_LOCKOUT;
        end else begin
          state_n = S_IDLE;
        end
      end

      S_LOCKOUT: begin
        but_n = '0;
        if (lock_cnt == LW'(LOCKOUT_CYCLES - 1)) begin
          lock_cnt_n = '0;
          fails_n    = '0;
          state_n    = S_IDLE;
        end else begin
          lock_cnt_n = lock_cnt + LW'(1);
        end
      end

      default: begin
        but_n   = '0;
        state_n = S_IDLE;
      end
    endcase

    fail_sat = (32'(fails_n) > 32'd3) ? 2'd3 : 2'(fails_n);
  end

  assign bus.but        = but_q;
  assign bus.open       = open_q;
  assign bus.lockout    = lockout_q;
  assign bus.fail_count = fail_count_q;

endmodule
`default_nettype wire

// File: tb/tb_padlock_keypad.sv
`default_nettype none
// ============================================================================
// Module   : tb_padlock_keypad
// Purpose  : Self-checking bench for padlock_keypad with a padlock model that
//            unlocks on code 10'h055 and a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_padlock_keypad;
  localparam int DEB  = 4;
  localparam int TMO  = 50;
  localparam int MAXF = 3;
  localparam int LOCK = 100;

  localparam int M_IDLE   = 0;
  localparam int M_ENTRY  = 1;
  localparam int M_SUBMIT = 2;
  localparam int M_CHECK  = 3;
  localparam int M_LOCK   = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  padlock_keypad_if kif();

  padlock_keypad #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TMO),
    .MAX_FAILS      (MAXF),
    .LOCKOUT_CYCLES (LOCK)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (kif)
  );

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream padlock: registers its verdict on each open strobe (1 = still locked)
  always @(posedge clk) begin
    if (reset) kif.lock_in <= 1'b1;
    else if (kif.open) kif.lock_in <= (kif.but != 10'h055);
  end

  // ------------------------------------------------------------------------
  // Reference model: raw inputs delayed two edges, a level flips once the
  // last DEB samples all disagree with it, a press is the rising edge of
  // that level and is acted on one edge later.
  // ------------------------------------------------------------------------
  logic [9:0]  e_but;
  logic        e_open, e_lock;
  int          e_fails, mode, idle_run, lock_left;
  logic [10:0] d1, d2, deb, pend, samp, newdeb;
  logic [10:0] win [DEB];
  logic [9:0]  kp;
  logic        ep;
  bit          all_diff;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      e_but = '0; e_open = 0; e_lock = 0; e_fails = 0;
      mode = M_IDLE; idle_run = 0; lock_left = 0;
      d1 = '0; d2 = '0; deb = '0; pend = '0;
      for (int k = 0; k < DEB; k++) win[k] = '0;
    end else begin
      kp = pend[9:0];
      ep = pend[10];
      case (mode)
        M_IDLE: begin
          if (ep) begin mode = M_SUBMIT; e_but = '0; end
          else if (kp != 0) begin e_but ^= kp; idle_run = 0; mode = M_ENTRY; end
        end
        M_ENTRY: begin
          if (ep) mode = M_SUBMIT;
          else if (kp != 0) begin e_but ^= kp; idle_run = 0; end
          else begin
            idle_run++;
            if (idle_run == TMO) begin e_but = '0; mode = M_IDLE; end
          end
        end
        M_SUBMIT: mode = M_CHECK;
        M_CHECK: begin
          if (e_but == 10'h055) e_fails = 0;
          else if (e_fails < MAXF) e_fails++;
          e_but = '0;
          if (e_fails == MAXF) begin mode = M_LOCK; lock_left = LOCK; end
          else mode = M_IDLE;
        end
        default: begin
          lock_left--;
          if (lock_left == 0) begin e_fails = 0; mode = M_IDLE; end
        end
      endcase
      e_open = (mode == M_SUBMIT);
      e_lock = (mode == M_LOCK);

      samp = d2;
      d2   = d1;
      d1   = {kif.enter_raw, kif.key_raw};
      for (int k = DEB - 1; k > 0; k--) win[k] = win[k-1];
      win[0] = samp;
      newdeb = deb;
      for (int b = 0; b < 11; b++) begin
        all_diff = 1'b1;
        for (int k = 0; k < DEB; k++) if (win[k][b] == deb[b]) all_diff = 1'b0;
        if (all_diff) newdeb[b] = ~deb[b];
      end
      pend = newdeb & ~deb;
      deb  = newdeb;
    end
  end

  // Cycle-by-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      check("cyc_but",     32'(kif.but),        32'(e_but));
      check("cyc_open",    32'(kif.open),       32'(e_open));
      check("cyc_lockout", 32'(kif.lockout),    32'(e_lock));
      check("cyc_fail",    32'(kif.fail_count), (e_fails > 3) ? 32'd3 : 32'(e_fails));
    end
  end

  // ------------------------------------------------------------------------
  // Stimulus helpers
  // ------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_key(input int k);
    @(negedge clk);
    kif.key_raw[k] = 1'b1;
    tick(10);
    kif.key_raw[k] = 1'b0;
    tick(10);
  endtask

  task automatic enter_pulse();
    @(negedge clk);
    kif.enter_raw = 1'b1;
    tick(10);
    kif.enter_raw = 1'b0;
    tick(10);
  endtask

  // Presses enter and reports cycles until open rises and how long it stays high
  task automatic do_enter(output int lat, output int width);
    lat = -1;
    width = 0;
    @(negedge clk);
    kif.enter_raw = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (kif.open) begin
        width++;
        if (lat < 0) lat = i;
      end
    end
    kif.enter_raw = 1'b0;
    tick(10);
  endtask

  task automatic enter_code(input logic [9:0] code);
    for (int k = 0; k < 10; k++) if (code[k]) press_key(k);
  endtask

  int lat, width;

  initial begin
    reset = 1'b1;
    kif.key_raw = '0;
    kif.enter_raw = 1'b0;
    tick(3);
    check("reset_but",     32'(kif.but),        32'h0);
    check("reset_open",    32'(kif.open),       32'h0);
    check("reset_lockout", 32'(kif.lockout),    32'h0);
    check("reset_fail",    32'(kif.fail_count), 32'h0);
    cmp_en = 1'b1;
    reset = 1'b0;
    tick(2);

    // 1. correct code
    enter_code(10'h055);
    check("t1_code", 32'(kif.but), 32'h055);
    do_enter(lat, width);
    check("t1_open_latency", 32'(lat), 32'd7);
    check("t1_open_width",   32'(width), 32'd1);
    check("t1_fail",         32'(kif.fail_count), 32'd0);
    check("t1_but_cleared",  32'(kif.but), 32'h0);

    // 2. bounce on key 3, then a short glitch on key 5
    for (int r = 0; r < 2; r++) begin
      @(negedge clk); kif.key_raw[3] = 1'b1; tick(1);
      kif.key_raw[3] = 1'b0; tick(1);
    end
    kif.key_raw[3] = 1'b1; tick(10);
    kif.key_raw[3] = 1'b0; tick(4);
    check("t2_bounce", 32'(kif.but), 32'h008);
    kif.key_raw[5] = 1'b1; tick(3);
    kif.key_raw[5] = 1'b0; tick(15);
    check("t2_glitch", 32'(kif.but), 32'h008);

    // 3. double toggle and inactivity timeout
    press_key(1);
    press_key(1);
    check("t3_toggle_back", 32'(kif.but), 32'h008);
    press_key(9);
    check("t3_key9", 32'(kif.but), 32'h208);
    tick(TMO);
    check("t3_timeout", 32'(kif.but), 32'h0);

    // 4. three wrong submits lead to lockout
    for (int a = 1; a <= 3; a++) begin
      press_key(0);
      do_enter(lat, width);
      check("t4_fail_count", 32'(kif.fail_count), 32'(a));
    end
    check("t4_lockout", 32'(kif.lockout), 32'd1);
    press_key(2);
    enter_pulse();
    check("t4_ignored_but",  32'(kif.but), 32'h0);
    check("t4_still_locked", 32'(kif.lockout), 32'd1);
    tick(60);
    check("t4_unlocked", 32'(kif.lockout), 32'd0);
    check("t4_fail_clr", 32'(kif.fail_count), 32'd0);

    // 5. wrong, wrong, correct
    for (int a = 1; a <= 2; a++) begin
      press_key(0);
      do_enter(lat, width);
      check("t5_fail_count", 32'(kif.fail_count), 32'(a));
    end
    enter_code(10'h055);
    do_enter(lat, width);
    check("t5_fail_reset", 32'(kif.fail_count), 32'd0);
    check("t5_no_lockout", 32'(kif.lockout), 32'd0);

    // 6. reset during ENTRY and during LOCKOUT
    enter_code(10'h055);
    check("t6_code", 32'(kif.but), 32'h055);
    reset = 1'b1;
    tick(1);
    check("t6_entry_but",  32'(kif.but),  32'h0);
    check("t6_entry_open", 32'(kif.open), 32'h0);
    reset = 1'b0;
    tick(20);
    for (int a = 1; a <= 3; a++) begin
      press_key(0);
      do_enter(lat, width);
    end
    check("t6_locked", 32'(kif.lockout), 32'd1);
    reset = 1'b1;
    tick(1);
    check("t6_lock_lockout", 32'(kif.lockout),    32'h0);
    check("t6_lock_fail",    32'(kif.fail_count), 32'h0);
    check("t6_lock_open",    32'(kif.open),       32'h0);
    reset = 1'b0;
    tick(30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
